// File: rtl/ins_issue_seq.sv
// Instruction fetch/issue sequencer: streams instructions from the instruction SRAM to CONTROL
// back-to-back, holding repeat-type opcodes for their repeat count and freezing on stall.
module ins_issue_seq #(
    parameter int INSWIDTH      = 19,
    parameter int INS_ADDRWIDTH = 10,
    parameter int REPWIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [INS_ADDRWIDTH-1:0] start_addr,
    input  logic                     stall,
    output logic                     ins_rd_en,
    output logic [INS_ADDRWIDTH-1:0] ins_addr,
    input  logic [INSWIDTH-1:0]      ins_rdata,
    output logic [INSWIDTH-1:0]      ins_data,
    output logic                     ins_valid,
    output logic                     busy,
    output logic                     done
);

    localparam logic [2:0] OP_MAC_R = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_END   = 3'b100;
    localparam logic [2:0] OP_MULTI = 3'b101;
    localparam logic [INSWIDTH-1:0]      NOP      = {3'b111, {(INSWIDTH-3){1'b0}}};
    localparam logic [INS_ADDRWIDTH-1:0] ADDR_ONE = 1;
    localparam logic [REPWIDTH-1:0]      REP_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [INS_ADDRWIDTH-1:0]   pc_q;
    logic [REPWIDTH-1:0]        rep_q;
    logic                       accept, load_ins, pc_inc, rep_dec, finish;
    logic [2:0]                 op_cur, op_rd;

    assign op_cur = ins_data[INSWIDTH-1 -: 3];
    assign op_rd  = ins_rdata[INSWIDTH-1 -: 3];

    // Remaining extra cycles after the first one; only repeat-type opcodes hold longer.
    function automatic logic [REPWIDTH-1:0] hold_rep(input logic [2:0] op,
                                                     input logic [REPWIDTH-1:0] field);
        if (op == OP_MAC_R || op == OP_ADD || op == OP_MULTI) return field;
        return '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ins_rd_en = 1'b0;
        ins_addr  = pc_q;
        accept    = 1'b0;
        load_ins  = 1'b0;
        pc_inc    = 1'b0;
        rep_dec   = 1'b0;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The read is already committed, so stall has no effect here.
                ins_rd_en = 1'b1;
                load_ins  = 1'b1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (rep_q != '0) begin
                        rep_dec = 1'b1;
                    end else if (op_cur == OP_END) begin
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // Prefetch in the final hold cycle so the next opcode follows with no gap.
                        ins_rd_en = 1'b1;
                        ins_addr  = pc_q + ADDR_ONE;
                        load_ins  = 1'b1;
                        pc_inc    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            rep_q     <= '0;
            ins_data  <= NOP;
            ins_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state_q == S_DONE);
            if (accept) begin
                pc_q <= start_addr;
                busy <= 1'b1;
            end
            if (state_q == S_DONE) busy <= 1'b0;
            if (pc_inc) pc_q <= pc_q + ADDR_ONE;
            if (load_ins) begin
                ins_data  <= ins_rdata;
                ins_valid <= (op_rd[2:1] != 2'b11);
                rep_q     <= hold_rep(op_rd, ins_rdata[REPWIDTH-1:0]);
            end else if (rep_dec) begin
                rep_q <= rep_q - REP_ONE;
            end
            if (finish) begin
                ins_data  <= NOP;
                ins_valid <= 1'b0;
            end
        end
    end

endmodule
